// File: rtl/int_controller.sv
// Multi-source interrupt controller: synchronises and latches requests, masks and
// arbitrates them by fixed priority with nesting, and keeps a return-address stack.
module int_controller #(
    parameter int                  DATA_W    = 16,
    parameter int                  NUM_SRC   = 8,
    parameter int                  DEPTH     = 4,
    parameter logic [DATA_W-1:0]   VEC_BASE  = 16'h0010,
    parameter int                  VEC_SHIFT = 2,
    parameter logic [NUM_SRC-1:0]  EDGE_MASK = '1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src,
    input  logic                        mask_wr,
    input  logic [NUM_SRC-1:0]          mask_din,
    input  logic                        gie_set,
    input  logic                        gie_clr,
    output logic                        int_req,
    input  logic                        int_ack,
    output logic [DATA_W-1:0]           int_vec,
    output logic [$clog2(NUM_SRC)-1:0]  int_id,
    input  logic [DATA_W-1:0]           retaddr_in,
    input  logic                        int_done,
    output logic [DATA_W-1:0]           retaddr_out,
    output logic                        ret_valid,
    output logic                        stack_err,
    output logic [NUM_SRC-1:0]          pending
);

    localparam int ID_W = $clog2(NUM_SRC);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [NUM_SRC-1:0]  s1_reg, s2_reg, s3_reg;
    logic [NUM_SRC-1:0]  pending_reg, pending_next;
    logic [NUM_SRC-1:0]  mask_reg;
    logic [NUM_SRC-1:0]  in_service_reg, in_service_next;
    logic [NUM_SRC-1:0]  eligible, ack_clr;
    logic                gie_reg, gie_next;
    logic [ID_W-1:0]     id_reg, cand;
    logic                has_cand, load_req;
    logic [DATA_W-1:0]   vec_reg;
    logic [SP_W-1:0]     sp_reg, sp_next, pop_ptr, push_ptr;
    logic [DATA_W-1:0]   stack_mem [DEPTH];
    logic [DATA_W-1:0]   retaddr_reg;
    logic                ret_valid_reg, stack_err_reg;
    logic                ack_ok, pop_ok;

    assign int_req     = (state_reg == REQ);
    assign int_vec     = vec_reg;
    assign int_id      = id_reg;
    assign retaddr_out = retaddr_reg;
    assign ret_valid   = ret_valid_reg;
    assign stack_err   = stack_err_reg;
    assign pending     = pending_reg;

    assign ack_ok   = (state_reg == REQ) && int_ack;
    assign pop_ok   = int_done && (sp_reg != '0);
    assign pop_ptr  = sp_reg - SP_W'(1);
    // A simultaneous pop and push share the popped slot, leaving sp unchanged.
    assign push_ptr = pop_ok ? pop_ptr : sp_reg;
    assign sp_next  = ack_ok ? push_ptr + SP_W'(1) : push_ptr;
    assign ack_clr  = ack_ok ? (NUM_SRC'(1) << id_reg) : '0;

    // Only sources strictly above every in-service level may interrupt.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign eligible[gi] = pending_reg[gi] & mask_reg[gi] & ~(|in_service_reg[gi:0]);
        assign pending_next[gi] = EDGE_MASK[gi]
            ? ((pending_reg[gi] & ~ack_clr[gi]) | (s2_reg[gi] & ~s3_reg[gi]))
            : s2_reg[gi];
    end

    always_comb begin
        has_cand = 1'b0;
        cand     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                has_cand = 1'b1;
                cand     = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gie_reg && has_cand && (sp_reg < SP_W'(DEPTH))) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop is applied before push; clear wins over set for the global enable.
    always_comb begin
        gie_next = gie_reg;
        if (gie_set) gie_next = 1'b1;
        if (gie_clr) gie_next = 1'b0;
        if (pop_ok)  gie_next = 1'b1;
        if (ack_ok)  gie_next = 1'b0;
        in_service_next = pop_ok ? (in_service_reg & (in_service_reg - NUM_SRC'(1)))
                                 : in_service_reg;
        if (ack_ok) in_service_next[id_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg         <= '0;
            s2_reg         <= '0;
            s3_reg         <= '0;
            pending_reg    <= '0;
            mask_reg       <= '0;
            in_service_reg <= '0;
            gie_reg        <= 1'b0;
            sp_reg         <= '0;
            id_reg         <= '0;
            vec_reg        <= '0;
            retaddr_reg    <= '0;
            ret_valid_reg  <= 1'b0;
            stack_err_reg  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
        end else begin
            s1_reg         <= src;
            s2_reg         <= s1_reg;
            s3_reg         <= s2_reg;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            gie_reg        <= gie_next;
            sp_reg         <= sp_next;
            ret_valid_reg  <= pop_ok;
            if (mask_wr) mask_reg <= mask_din;
            if (load_req) begin
                id_reg  <= cand;
                vec_reg <= VEC_BASE + (DATA_W'(cand) << VEC_SHIFT);
            end
            if (pop_ok) retaddr_reg <= stack_mem[pop_ptr[AW-1:0]];
            if (int_done && (sp_reg == '0)) stack_err_reg <= 1'b1;
            if (ack_ok) stack_mem[push_ptr[AW-1:0]] <= retaddr_in;
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: edge/level sources, priority nesting, stack
// limits, frozen requests, simultaneous ack/done and asynchronous reset.
module tb_int_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src;
    logic        mask_wr;
    logic [7:0]  mask_din;
    logic        gie_set, gie_clr;
    logic        int_req, int_ack, int_done;
    logic [15:0] int_vec, retaddr_in, retaddr_out;
    logic [2:0]  int_id;
    logic        ret_valid, stack_err;
    logic [7:0]  pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_controller #(
        .DATA_W(16), .NUM_SRC(8), .DEPTH(4), .VEC_BASE(16'h0010),
        .VEC_SHIFT(2), .EDGE_MASK(8'hFD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src(src), .mask_wr(mask_wr), .mask_din(mask_din),
        .gie_set(gie_set), .gie_clr(gie_clr), .int_req(int_req), .int_ack(int_ack),
        .int_vec(int_vec), .int_id(int_id), .retaddr_in(retaddr_in), .int_done(int_done),
        .retaddr_out(retaddr_out), .ret_valid(ret_valid), .stack_err(stack_err),
        .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bits rise between edges 0 and 1 and fall one cycle later; returns after edge 4.
    task automatic pulse(input logic [7:0] bits);
        src = src | bits;
        tick(1);
        src = src & ~bits;
        tick(3);
    endtask

    task automatic ack(input logic [15:0] addr);
        int_ack    = 1'b1;
        retaddr_in = addr;
        tick(1);
        int_ack    = 1'b0;
    endtask

    task automatic done();
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
    endtask

    task automatic set_gie();
        gie_set = 1'b1;
        tick(1);
        gie_set = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_wr  = 1'b1;
        mask_din = m;
        tick(1);
        mask_wr  = 1'b0;
    endtask

    task automatic expect_req(input string tag, input logic [2:0] id, input logic [15:0] vec);
        check({tag, "_req"}, 32'(int_req), 32'd1);
        check({tag, "_id"},  32'(int_id),  32'(id));
        check({tag, "_vec"}, 32'(int_vec), 32'(vec));
    endtask

    task automatic expect_ret(input string tag, input logic [15:0] addr);
        check({tag, "_valid"}, 32'(ret_valid),   32'd1);
        check({tag, "_addr"},  32'(retaddr_out), 32'(addr));
    endtask

    logic [7:0]  nest_bits [4] = '{8'h40, 8'h10, 8'h08, 8'h04};
    logic [2:0]  nest_ids  [4] = '{3'd6, 3'd4, 3'd3, 3'd2};
    logic [15:0] nest_vecs [4] = '{16'h0028, 16'h0020, 16'h001C, 16'h0018};

    initial begin
        rst_n = 1'b0; src = '0; mask_wr = 1'b0; mask_din = '0; gie_set = 1'b0;
        gie_clr = 1'b0; int_ack = 1'b0; int_done = 1'b0; retaddr_in = '0;
        tick(2);
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_stack_err", 32'(stack_err), 32'd0);
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_vec", 32'(int_vec), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single edge source with exact latency
        mask_wr = 1'b1; mask_din = 8'h08; gie_set = 1'b1;
        tick(1);
        mask_wr = 1'b0; gie_set = 1'b0;
        src[3] = 1'b1;
        tick(1);
        src[3] = 1'b0;
        tick(2);
        check("t1_pending_e3", 32'(pending), 32'h08);
        check("t1_req_e3", 32'(int_req), 32'd0);
        tick(1);
        expect_req("t1", 3'd3, 16'h001C);
        ack(16'h1234);
        check("t1_req_after_ack", 32'(int_req), 32'd0);
        check("t1_pending_after_ack", 32'(pending), 32'h00);
        done();
        expect_ret("t1_ret", 16'h1234);
        tick(1);
        check("t1_ret_pulse_end", 32'(ret_valid), 32'd0);

        // Priority and nesting
        write_mask(8'hFF);
        pulse(8'h24);
        expect_req("t2_first", 3'd2, 16'h0018);
        ack(16'h2000);
        check("t2_pending5", 32'(pending), 32'h20);
        set_gie();
        tick(2);
        check("t2_src5_blocked", 32'(int_req), 32'd0);
        pulse(8'h01);
        expect_req("t2_preempt", 3'd0, 16'h0010);
        ack(16'h3000);
        done();
        expect_ret("t2_pop0", 16'h3000);
        done();
        expect_ret("t2_pop1", 16'h2000);
        check("t2_req_after_pop", 32'(int_req), 32'd0);
        tick(1);
        expect_req("t2_src5", 3'd5, 16'h0024);
        ack(16'h5555);
        done();
        expect_ret("t2_pop2", 16'h5555);

        // Stack full
        for (int i = 0; i < 4; i++) begin
            pulse(nest_bits[i]);
            expect_req($sformatf("t3_nest%0d", i), nest_ids[i], nest_vecs[i]);
            ack(16'(i + 1));
            set_gie();
        end
        pulse(8'h01);
        tick(2);
        check("t3_full_no_req", 32'(int_req), 32'd0);
        check("t3_full_pending", 32'(pending), 32'h01);
        write_mask(8'h00);
        for (int i = 0; i < 4; i++) begin
            done();
            expect_ret($sformatf("t3_pop%0d", i), 16'(4 - i));
        end
        check("t3_err_before", 32'(stack_err), 32'd0);
        done();
        check("t3_err_after", 32'(stack_err), 32'd1);
        check("t3_underflow_valid", 32'(ret_valid), 32'd0);
        write_mask(8'hFF);
        check("t3_mask_not_yet", 32'(int_req), 32'd0);
        tick(1);
        expect_req("t3_drain", 3'd0, 16'h0010);
        ack(16'h0000);
        done();

        // Level versus edge
        src[1] = 1'b1;
        tick(4);
        expect_req("t4_level", 3'd1, 16'h0014);
        ack(16'h0101);
        check("t4_pending_kept", 32'(pending), 32'h02);
        done();
        expect_ret("t4_ret", 16'h0101);
        tick(1);
        expect_req("t4_reassert", 3'd1, 16'h0014);
        src[1] = 1'b0;
        tick(2);
        check("t4_pending_e2", 32'(pending), 32'h02);
        tick(1);
        check("t4_pending_e3", 32'(pending), 32'h00);
        ack(16'h0202);
        done();

        // Frozen request
        pulse(8'h10);
        expect_req("t5_req", 3'd4, 16'h0020);
        mask_wr = 1'b1; mask_din = 8'h00; gie_clr = 1'b1;
        tick(1);
        mask_wr = 1'b0; gie_clr = 1'b0;
        tick(1);
        expect_req("t5_frozen", 3'd4, 16'h0020);
        ack(16'h9999);

        // Simultaneous ack and done with sp=2
        mask_wr = 1'b1; mask_din = 8'hFF; gie_set = 1'b1;
        tick(1);
        mask_wr = 1'b0; gie_set = 1'b0;
        pulse(8'h08);
        expect_req("t6_id3", 3'd3, 16'h001C);
        ack(16'hAAAA);
        set_gie();
        pulse(8'h04);
        expect_req("t6_id2", 3'd2, 16'h0018);
        int_ack = 1'b1; retaddr_in = 16'hBBBB; int_done = 1'b1;
        tick(1);
        int_ack = 1'b0; int_done = 1'b0;
        check("t6_req_dropped", 32'(int_req), 32'd0);
        expect_ret("t6_both", 16'hAAAA);
        done();
        expect_ret("t6_top", 16'hBBBB);
        done();
        expect_ret("t6_bottom", 16'h9999);
        done();
        check("t6_empty", 32'(ret_valid), 32'd0);

        // Reset mid-operation
        pulse(8'h40);
        expect_req("t7_req", 3'd6, 16'h0028);
        rst_n = 1'b0;
        #2;
        check("t7_req_async", 32'(int_req), 32'd0);
        check("t7_pending", 32'(pending), 32'd0);
        check("t7_stack_err", 32'(stack_err), 32'd0);
        check("t7_id", 32'(int_id), 32'd0);
        check("t7_retaddr", 32'(retaddr_out), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        pulse(8'h40);
        tick(1);
        check("t7_masked_after_rst", 32'(int_req), 32'd0);
        check("t7_pending_latched", 32'(pending), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
